// File: rtl/sprite_arb_pkg.sv
// Shared types for the two-requester sprite ROM arbiter.
// The tag travels alongside each ROM read to route the returned word.
package sprite_arb_pkg;
   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 14;
   localparam int DATA_W  = 3;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;
endpackage

// File: rtl/sprite_rom_arbiter_rr_arbiter2.sv
// Two-way grant logic: fixed priority or round-robin.
// Holds the identity of the last winner for round-robin ties.
module rr_arbiter2
   import sprite_arb_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_prio_mode,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_gnt,
   output req_id_t            o_gnt_id
);

   req_id_t            r_last_gnt;
   logic [NUM_REQ-1:0] w_gnt;

   // A tie goes to requester 0 unless it won last time.
   always_comb begin
      w_gnt = '0;
      if (i_rst) begin
         w_gnt = '0;
      end else if (i_req == 2'b11) begin
         if (i_prio_mode || r_last_gnt) begin
            w_gnt = 2'b01;
         end else begin
            w_gnt = 2'b10;
         end
      end else begin
         w_gnt = i_req;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last_gnt <= 1'b1;
      end else if (|w_gnt) begin
         r_last_gnt <= w_gnt[1];
      end
   end

   assign o_gnt    = w_gnt;
   assign o_gnt_id = w_gnt[1];

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port between the two fighter renderers.
// A tag pipeline matching the ROM latency steers each word back.
module sprite_rom_arbiter #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 3,
   parameter int ROM_LAT = 1
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic              prio_mode,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q
);
   import sprite_arb_pkg::*;

   logic [1:0]  w_gnt;
   req_id_t     w_gnt_id;
   tag_t        w_tag_out;

   tag_t [ROM_LAT-1:0] r_tag;
   logic [1:0]         r_rvalid;
   logic [DATA_W-1:0]  r_rdata;

   rr_arbiter2 u_arb (
      .i_clk       (vga_clk),
      .i_rst       (reset),
      .i_prio_mode (prio_mode),
      .i_req       (req),
      .o_gnt       (w_gnt),
      .o_gnt_id    (w_gnt_id)
   );

   assign gnt       = w_gnt;
   assign rom_addr  = w_gnt[1] ? addr1 :
                      w_gnt[0] ? addr0 : '0;
   assign w_tag_out = r_tag[ROM_LAT-1];

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_tag <= '0;
      end else begin
         r_tag[0] <= '{valid: |w_gnt, id: w_gnt_id};
         for (int i = 1; i < ROM_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   // rdata only moves when a tagged read lands, so it holds when idle.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_rvalid <= 2'b00;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= 2'b00;
         if (w_tag_out.valid) begin
            r_rvalid[w_tag_out.id] <= 1'b1;
            r_rdata                <= rom_q;
         end
      end
   end

   assign rvalid = r_rvalid;
   assign rdata  = r_rdata;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Drives two arbiter instances (ROM latency 1 and 3) in lockstep and
// checks them against a queue-based model of grants and returns.
module tb_sprite_rom_arbiter;

   localparam int AW = 14;
   localparam int DW = 3;

   logic          clk;
   logic          rst;
   logic          prio;
   logic [1:0]    req;
   logic [AW-1:0] a0;
   logic [AW-1:0] a1;

   logic [1:0]    gnt_a, rv_a, gnt_b, rv_b;
   logic [DW-1:0] rd_a, q_a, rd_b, q_b;
   logic [AW-1:0] ra_a, ra_b;

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] pa;
   logic [AW-1:0] pb [3];

   int checks = 0;
   int errors = 0;

   sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut_a (
      .vga_clk (clk), .reset (rst), .prio_mode (prio), .req (req),
      .addr0 (a0), .addr1 (a1), .gnt (gnt_a), .rvalid (rv_a),
      .rdata (rd_a), .rom_addr (ra_a), .rom_q (q_a)
   );

   sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut_b (
      .vga_clk (clk), .reset (rst), .prio_mode (prio), .req (req),
      .addr0 (a0), .addr1 (a1), .gnt (gnt_b), .rvalid (rv_b),
      .rdata (rd_b), .rom_addr (ra_b), .rom_q (q_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous ROMs with 1 and 3 register stages.
   always @(posedge clk) begin
      pa    <= ra_a;
      pb[0] <= ra_b;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign q_a = mem[pa];
   assign q_b = mem[pb[2]];

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          qa[$];
   ent_t          qb[$];
   logic [DW-1:0] hold_a;
   logic [DW-1:0] hold_b;
   bit            last;
   int            cyc;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic p, input logic [1:0] rq,
                       input logic [AW-1:0] x0, input logic [AW-1:0] x1);
      logic [1:0]    eg;
      logic [AW-1:0] ea;
      logic [1:0]    ev;
      ent_t          e;
      rst  = r;
      prio = p;
      req  = rq;
      a0   = x0;
      a1   = x1;
      @(negedge clk);
      if (r) eg = 2'b00;
      else if (rq == 2'b11) eg = (p || last) ? 2'b01 : 2'b10;
      else eg = rq;
      ea = eg[1] ? x1 : (eg[0] ? x0 : '0);
      chk("gnt_a", 32'(gnt_a), 32'(eg));
      chk("gnt_b", 32'(gnt_b), 32'(eg));
      chk("rom_addr_a", 32'(ra_a), 32'(ea));
      chk("rom_addr_b", 32'(ra_b), 32'(ea));
      chk("gnt_not_11", 32'(gnt_a == 2'b11), 32'd0);
      if (r) begin
         qa.delete();
         qb.delete();
         hold_a = '0;
         hold_b = '0;
      end
      ev = 2'b00;
      if (qa.size() > 0 && qa[0].due == cyc) begin
         ev     = 2'b01 << qa[0].id;
         hold_a = qa[0].d;
         void'(qa.pop_front());
      end
      chk("rvalid_a", 32'(rv_a), 32'(ev));
      chk("rdata_a", 32'(rd_a), 32'(hold_a));
      ev = 2'b00;
      if (qb.size() > 0 && qb[0].due == cyc) begin
         ev     = 2'b01 << qb[0].id;
         hold_b = qb[0].d;
         void'(qb.pop_front());
      end
      chk("rvalid_b", 32'(rv_b), 32'(ev));
      chk("rdata_b", 32'(rd_b), 32'(hold_b));
      chk("rvalid_not_11", 32'(rv_b == 2'b11), 32'd0);
      @(posedge clk);
      if (r) begin
         last = 1'b1;
      end else if (eg != 2'b00) begin
         last = eg[1];
         e.id = eg[1] ? 1 : 0;
         e.d  = mem[ea];
         e.due = cyc + 2;
         qa.push_back(e);
         e.due = cyc + 4;
         qb.push_back(e);
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, '0, '0);
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
      mem[5]  = 3'd3;
      mem[10] = 3'd6;
      mem[20] = 3'd1;
      last   = 1'b1;
      hold_a = '0;
      hold_b = '0;
      cyc    = 0;

      step(1'b1, 1'b0, 2'b00, '0, '0);
      step(1'b1, 1'b0, 2'b11, 14'd7, 14'd9);

      // single request from player 1
      step(1'b0, 1'b0, 2'b01, 14'd5, '0);
      idle(4);

      // round-robin alternation on a held tie
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b11, 14'd10, 14'd20);
      idle(4);

      // fixed priority, then back to round-robin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b11, 14'd10, 14'd20);
      step(1'b0, 1'b0, 2'b11, 14'd10, 14'd20);
      idle(4);

      // reset flushes an in-flight read from requester 1
      step(1'b0, 1'b0, 2'b10, '0, 14'd20);
      step(1'b1, 1'b0, 2'b00, '0, '0);
      idle(4);
      step(1'b0, 1'b0, 2'b11, 14'd5, 14'd20);
      idle(4);

      // back-to-back grants with a bubble
      step(1'b0, 1'b0, 2'b01, 14'd100, 14'd200);
      step(1'b0, 1'b0, 2'b10, 14'd100, 14'd200);
      step(1'b0, 1'b0, 2'b00, 14'd100, 14'd200);
      step(1'b0, 1'b0, 2'b01, 14'd300, 14'd200);
      idle(5);

      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), 1'($urandom),
              2'($urandom), AW'($urandom), AW'($urandom));
      end
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
